multiplier: RTL and testbench
=============================

// Module: multiplier
//
// PURPOSE
//   Fully pipelined unsigned integer multiplier, DATA_LEN x DATA_LEN -> DATA_LEN (low half).
//   Sits behind the AFU control FSM. The FSM presents one operand pair for a single
//   cycle, waits a fixed number of cycles, then samples result and writes it to host memory.
//   Accepts a new operand pair every cycle, with no handshake. Latency is fixed by parameter.
//
// PARAMETERS
//   DATA_LEN        32  operand and result width in bits (>= 2)
//   PIPELINE_STAGE  2   internal pipeline register stages after the input register (>= 0)
//
// PORTS
//   clk     input   1         rising-edge clock
//   reset   input   1         asynchronous, active-high reset
//   a       input   DATA_LEN  multiplicand, unsigned
//   b       input   DATA_LEN  multiplier, unsigned
//   result  output  DATA_LEN  (a*b) mod 2^DATA_LEN, registered
//
// BEHAVIOUR
//   - Reset
//     - One clock; reset is asynchronous and active-high.
//     - While reset is high, every pipeline register is cleared to 0, including the input
//       register and the output register. result = 0.
//     - Deassertion is sampled on the next clk rising edge.
//     - Reset mid-operation discards all in-flight products; nothing is replayed.
//   - Latency
//     - L = PIPELINE_STAGE + 1 clock edges.
//     - Structure: input register (a,b captured) -> PIPELINE_STAGE register stages -> result.
//     - a,b sampled at edge N appear on result immediately after edge N+L.
//     - result holds that value for exactly one cycle, then shows the next sample.
//     - The product may be split across stages, e.g. DATA_LEN/2 partial products summed in
//       later stages. Latency must stay exactly L for every PIPELINE_STAGE value.
//   - Throughput
//     - One operation per cycle, no stalls, no valid/ready.
//     - Idle inputs (a=b=0) propagate as result 0.
//   - Arithmetic
//     - Unsigned.
//     - result = low DATA_LEN bits of the 2*DATA_LEN-bit product. Overflow silently wraps.
//     - No sign handling, no saturation.
//   - PIPELINE_STAGE = 0 gives L = 1: a single input register plus combinational multiply
//     feeding a registered result. The implementation must keep result registered, so the
//     effective L in this case is 1.
//   - No X propagation after reset; every register has a defined reset value.
//   - System context: with the defaults (L = 3), operands are valid for only one cycle and
//     the caller samples result 4 edges after presenting them. The output must be valid in
//     that exact cycle.
//
// TESTING
//   - Reset: assert reset with a=5, b=5 toggling -> result stays 0. Release reset
//     -> first nonzero result appears 3 edges after the first sample.
//   - Single op: a=7, b=6 for one cycle at edge N, then 0 -> result = 42 only in the cycle
//     after edge N+3, and 0 before and after.
//   - Wrap: a=0xFFFFFFFF, b=2 -> 0xFFFFFFFE. a=0x00010000, b=0x00010000 -> 0x00000000.
//     a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000001.
//   - Streaming: back-to-back pairs (3,4), (10,10), (0,123), (65535,65535) on consecutive
//     cycles -> 12, 100, 0, 0xFFFE0001 on consecutive cycles, starting at edge +3.
//   - Reset mid-flight: present (9,9), assert reset one cycle later -> result stays 0.
//     81 never appears.
//   - Parameter sweep: PIPELINE_STAGE = 0, 1, 4 with a=1000, b=1000 -> result = 1000000
//     after exactly 1, 2, 5 edges respectively.

Source files
------------

// File: rtl/multiplier.sv
// Pipelined unsigned DATA_LEN x DATA_LEN multiplier keeping the low DATA_LEN bits.
// Input register, PIPELINE_STAGE further stages, then a registered result: latency PIPELINE_STAGE+1.
module multiplier #(
  parameter int DATA_LEN       = 32,
  parameter int PIPELINE_STAGE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  output logic [DATA_LEN-1:0] result
);

  localparam int HALF = DATA_LEN / 2;

  logic [DATA_LEN-1:0] a_d, a_q;
  logic [DATA_LEN-1:0] b_d, b_q;

  always_comb begin
    a_d = a;
    b_d = b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  generate
    if (PIPELINE_STAGE == 0) begin : g_direct
      logic [DATA_LEN-1:0] res_d, res_q;

      always_comb res_d = a_q * b_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) res_q <= '0;
        else       res_q <= res_d;
      end

      assign result = res_q;
    end else begin : g_split
      // Split b into halves: two narrower partial products, summed one stage later.
      // Both partials are already truncated to DATA_LEN, so the sum wraps correctly.
      logic [DATA_LEN-1:0] lo_d, lo_q;
      logic [DATA_LEN-1:0] hi_d, hi_q;
      logic [DATA_LEN-1:0] chain_d [PIPELINE_STAGE];
      logic [DATA_LEN-1:0] chain_q [PIPELINE_STAGE];

      always_comb begin
        lo_d       = a_q * {{(DATA_LEN-HALF){1'b0}}, b_q[HALF-1:0]};
        hi_d       = a_q * {b_q[DATA_LEN-1:HALF], {HALF{1'b0}}};
        chain_d[0] = lo_q + hi_q;
        for (int i = 1; i < PIPELINE_STAGE; i++) chain_d[i] = chain_q[i-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lo_q <= '0;
          hi_q <= '0;
          for (int i = 0; i < PIPELINE_STAGE; i++) chain_q[i] <= '0;
        end else begin
          lo_q <= lo_d;
          hi_q <= hi_d;
          for (int i = 0; i < PIPELINE_STAGE; i++) chain_q[i] <= chain_d[i];
        end
      end

      assign result = chain_q[PIPELINE_STAGE-1];
    end
  endgenerate

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for multiplier: default instance plus PIPELINE_STAGE 0/1/4 variants.
module tb_multiplier;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [31:0] res, r0, r1, r4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2)) u_dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .result(res));
  multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(0)) u_ps0 (
    .clk(clk), .reset(reset), .a(a), .b(b), .result(r0));
  multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(1)) u_ps1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .result(r1));
  multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(4)) u_ps4 (
    .clk(clk), .reset(reset), .a(a), .b(b), .result(r4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    a = '0;
    b = '0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  logic [31:0] va [7];
  logic [31:0] vb [7];
  logic [31:0] ve [7];

  // Pairs lo..hi on consecutive edges; result j-3 is expected after edge j.
  task automatic run_stream(input string tag, input int lo, input int hi);
    int n;
    n = hi - lo + 1;
    for (int j = 0; j < n + 3; j++) begin
      a = (j < n) ? va[lo+j] : 32'd0;
      b = (j < n) ? vb[lo+j] : 32'd0;
      tick();
      chk(tag, res, (j >= 3) ? ve[lo+j-3] : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, n_vec %0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'd2;          ve[0] = 32'hFFFF_FFFE;
    va[1] = 32'h0001_0000; vb[1] = 32'h0001_0000;  ve[1] = 32'h0000_0000;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF;  ve[2] = 32'h0000_0001;
    va[3] = 32'd3;         vb[3] = 32'd4;          ve[3] = 32'd12;
    va[4] = 32'd10;        vb[4] = 32'd10;         ve[4] = 32'd100;
    va[5] = 32'd0;         vb[5] = 32'd123;        ve[5] = 32'd0;
    va[6] = 32'd65535;     vb[6] = 32'd65535;      ve[6] = 32'hFFFE_0001;

    // Reset held with toggling operands: everything stays 0.
    #2 reset = 1'b1;
    #1;
    chk("reset_async", res, 32'd0);
    chk("reset_ps0", r0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 32'd5 : 32'd0;
      b = (i % 2 == 0) ? 32'd5 : 32'd0;
      tick();
      chk("reset_hold", res, 32'd0);
      chk("reset_hold_ps4", r4, 32'd0);
    end

    // Release: first sample 5*5 emerges 3 edges after capture.
    reset = 1'b0;
    a = 32'd5;
    b = 32'd5;
    tick();
    a = '0;
    b = '0;
    tick(); chk("release_e1", res, 32'd0);
    tick(); chk("release_e2", res, 32'd0);
    tick(); chk("release_e3", res, 32'd25);
    tick(); chk("release_e4", res, 32'd0);

    // Single op visible for exactly one cycle.
    flush();
    a = 32'd7;
    b = 32'd6;
    tick();
    a = '0;
    b = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("single_op", res, (k == 3) ? 32'd42 : 32'd0);
    end

    flush();
    run_stream("wrap", 0, 2);
    flush();
    run_stream("stream", 3, 6);

    // Reset asserted one cycle after (9,9): 81 never shows.
    flush();
    a = 32'd9;
    b = 32'd9;
    tick();
    a = '0;
    b = '0;
    tick();
    reset = 1'b1;
    #1;
    chk("midflight_async", res, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("midflight_hold", res, 32'd0);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midflight_after", res, 32'd0);
    end

    // Asynchronous clear of a visible result, no clock edge needed.
    flush();
    a = 32'd2;
    b = 32'd3;
    tick();
    a = '0;
    b = '0;
    tick();
    tick();
    tick();
    chk("async_pre", res, 32'd6);
    reset = 1'b1;
    #1;
    chk("async_clear", res, 32'd0);
    tick();
    reset = 1'b0;

    // Latency sweep across PIPELINE_STAGE 0, 1, 4.
    flush();
    a = 32'd1000;
    b = 32'd1000;
    tick();
    a = '0;
    b = '0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("sweep_ps0", r0, (k == 1) ? 32'd1000000 : 32'd0);
      chk("sweep_ps1", r1, (k == 2) ? 32'd1000000 : 32'd0);
      chk("sweep_ps4", r4, (k == 5) ? 32'd1000000 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
